// File: rtl/generic_bus_arbiter.sv
// Round-robin arbiter sharing one generic bus master port among NUM_HARTS requesters.
// One registered arbitration cycle; grant held for a transaction or a locked sequence.
module generic_bus_arbiter #(
  parameter int NUM_HARTS = 2,
  parameter int IDW       = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_HARTS-1:0]   req_ren,
  input  logic [NUM_HARTS-1:0]   req_wen,
  input  logic [NUM_HARTS-1:0]   req_lock,
  input  logic [32*NUM_HARTS-1:0] req_addr,
  input  logic [32*NUM_HARTS-1:0] req_wdata,
  input  logic [4*NUM_HARTS-1:0] req_byte_en,
  output logic [NUM_HARTS-1:0]   req_busy,
  output logic [NUM_HARTS-1:0]   req_error,
  output logic [31:0]            req_rdata,
  output logic                   bus_ren,
  output logic                   bus_wen,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_wdata,
  output logic [3:0]             bus_byte_en,
  input  logic                   bus_busy,
  input  logic                   bus_error,
  input  logic [31:0]            bus_rdata,
  output logic                   grant_valid,
  output logic [IDW-1:0]         grant_id
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e               state_q;
  logic [IDW-1:0]       grant_id_q;
  logic [IDW-1:0]       last_q;
  logic [NUM_HARTS-1:0] reqs;
  logic                 active;
  logic                 own_ren, own_wen, own_lock, own_req;
  logic [31:0]          own_addr, own_wdata;
  logic [3:0]           own_be;
  logic                 pick_vld;
  logic [IDW-1:0]       pick_id;

  assign reqs    = req_ren | req_wen;
  assign active  = (state_q == ACTIVE);
  assign own_req = own_ren | own_wen;

  always_comb begin
    own_ren   = 1'b0;
    own_wen   = 1'b0;
    own_lock  = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    own_be    = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (grant_id_q == IDW'(i)) begin
        own_ren   = req_ren[i];
        own_wen   = req_wen[i];
        own_lock  = req_lock[i];
        own_addr  = req_addr[32*i +: 32];
        own_wdata = req_wdata[32*i +: 32];
        own_be    = req_byte_en[4*i +: 4];
      end
    end
  end

  // Scan last+1, last+2, ... with wrap; the first requester found wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 1; k <= NUM_HARTS; k++) begin
      idx = (int'(last_q) + k) % NUM_HARTS;
      if (!pick_vld && reqs[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IDW'(idx);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_q     <= IDW'(NUM_HARTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q    <= ACTIVE;
            grant_id_q <= pick_id;
          end
        end
        ACTIVE: begin
          if (!own_req) begin
            state_q <= IDLE;
            last_q  <= grant_id_q;
          end else if (!bus_busy) begin
            last_q <= grant_id_q;
            if (!own_lock) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_ren     = active & own_ren;
  assign bus_wen     = active & own_wen;
  assign bus_addr    = active ? own_addr  : '0;
  assign bus_wdata   = active ? own_wdata : '0;
  assign bus_byte_en = active ? own_be    : '0;
  assign req_rdata   = bus_rdata;
  assign grant_valid = active;
  assign grant_id    = grant_id_q;

  // Non-owners always see busy=1, error=0.
  always_comb begin
    req_busy  = '1;
    req_error = '0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (active && grant_id_q == IDW'(i)) begin
        req_busy[i]  = bus_busy;
        req_error[i] = bus_error & ~bus_busy;
      end
    end
  end

endmodule

// File: doc/generic_bus_arbiter.md
# generic_bus_arbiter

Round-robin arbiter that shares one generic bus master port among `NUM_HARTS` requesters, which are the per-hart instruction and data generic bus masters inside `multicore_wrapper`. It sits between the harts and the core's top-level generic bus pins. Arbitration takes one registered cycle. The grant is held for a whole transaction, or for a locked sequence used by LR/SC and AMO. Only the granted requester ever sees `busy` low.

## Interface
- `NUM_HARTS`, default 2: number of requesters; must be ≥1.
- `IDW`, default `$clog2(NUM_HARTS)` (minimum 1): width of the grant index.

Ports:
- `CLK`  in  1  clock; all state updates on rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `req_ren`  in  NUM_HARTS  read request per requester.
- `req_wen`  in  NUM_HARTS  write request per requester.
- `req_lock`  in  NUM_HARTS  keep the grant after the current transaction completes.
- `req_addr`  in  32*NUM_HARTS  address; requester i occupies bits [32i+31:32i].
- `req_wdata`  in  32*NUM_HARTS  write data, same packing as `req_addr`.
- `req_byte_en`  in  4*NUM_HARTS  byte enables; requester i occupies bits [4i+3:4i].
- `req_busy`  out  NUM_HARTS  per-requester busy.
- `req_error`  out  NUM_HARTS  per-requester error.
- `req_rdata`  out  32  read data, broadcast to all requesters.
- `bus_ren`, `bus_wen`  out  1  bus request.
- `bus_addr`, `bus_wdata`  out  32  bus address and write data.
- `bus_byte_en`  out  4  bus byte enables.
- `bus_busy`, `bus_error`  in  1  bus status.
- `bus_rdata`  in  32  bus read data.
- `grant_valid`  out  1  high in ACTIVE.
- `grant_id`  out  IDW  index of the current owner.

## Operation
- Requester i is "requesting" when `req_ren[i] | req_wen[i]` is high. The protocol matches the generic bus: a requester holds ren/wen, addr, wdata and byte_en stable until it sees its `req_busy` low.
- The FSM has two states: IDLE and ACTIVE.
- **IDLE**
  - Bus outputs ren, wen, addr, wdata and byte_en are all 0.
  - If any requester is requesting, the arbiter picks the first requesting index scanning `last+1, last+2, …` with wrap modulo NUM_HARTS.
  - The choice is registered into `grant_id` and the FSM moves to ACTIVE.
- **ACTIVE**
  - The granted requester's ren, wen, addr, wdata and byte_en are passed combinationally to the bus.
  - `req_busy[grant_id]` = `bus_busy`.
  - `req_error[grant_id]` = `bus_error & ~bus_busy`.
  - All other requesters see busy=1 and error=0.
  - `req_rdata` = `bus_rdata` at all times.
- **Completion** occurs in an ACTIVE cycle where `bus_busy`=0 and the owner is requesting.
  - `last` ← `grant_id` at every completion.
  - If `req_lock[grant_id]`=1, the FSM stays in ACTIVE with the same owner (back-to-back transactions with no dead cycle).
  - Otherwise the FSM moves to IDLE.
- **Abandon:** if the owner is in ACTIVE and not requesting (ren=wen=0), the FSM goes to IDLE next cycle and `last` ← `grant_id`. No bus request is driven in that cycle.
- **Simultaneous ren and wen** from the owner are forwarded unchanged; protocol checking is not this block's job.
- A lock held by one requester can starve the others. Harts must bound locked sequences; the arbiter enforces no limit.
- **NUM_HARTS=1:** the scan logic is still used; behaviour reduces to one dead cycle per unlocked transaction.

## Timing
- **Reset:** state=IDLE, `grant_id`=0, `grant_valid`=0, `last`=NUM_HARTS-1 (requester 0 has first priority).
  - Reset outputs: `bus_ren`=`bus_wen`=0, `bus_addr`=`bus_wdata`=0, `bus_byte_en`=0, `req_busy`=all ones, `req_error`=0.
- **Grant latency:** a request first seen in IDLE at cycle n reaches the bus in cycle n+1.
  - With a zero-wait bus (`bus_busy`=0 in n+1), the requester completes in cycle n+1.
  - Unlocked back-to-back transactions cost one IDLE cycle each.
- **Reset mid-transaction:** the bus request drops asynchronously and the owner's transaction is lost. The requester must reissue after reset.
- **Grant timing:** `req_busy` and `req_error` are combinational from the bus inputs in ACTIVE. `grant_id` and `grant_valid` are registered outputs.

## Test plan
- **Single request:** hart 1 asserts ren at addr 0x80000010; the bus responds with busy low 2 cycles after it sees ren, rdata 0xDEADBEEF.
  - `bus_ren`=1 from cycle 1 with addr 0x80000010.
  - `req_busy[1]`=0 in cycle 3 with `req_rdata`=0xDEADBEEF.
  - Hart 0 sees busy=1 throughout.
- **Contention:** harts 0 and 1 both write from reset with zero-wait completion.
  - Hart 0 is granted first (cycles 1–2).
  - Hart 1 is granted next (cycles 3–4).
- **Fairness:** 3 harts request continuously for 9 transactions → grant order 0,1,2,0,1,2,0,1,2.
- **Lock:** hart 0 holds `req_lock`=1 for 3 zero-wait transactions while hart 1 requests.
  - Hart 0 completes on 3 consecutive cycles.
  - Hart 1 is granted only after hart 0's lock drops.
- **Error and abandon:**
  - `bus_error`=1 with busy low → only the owner's `req_error` pulses for 1 cycle.
  - An owner that drops ren mid-wait → IDLE next cycle, bus outputs 0.
- **Reset mid-op:** assert RST while ACTIVE with busy high.
  - All outputs reach reset values without waiting for a clock edge.
  - After release, hart 0 has priority.
